// File: rtl/processor_stage3.sv
// processor_stage3: execute/writeback stage.
// Computes ALU, multiply-shift, immediate and load results for the register
// file writeback, resolves IF/CALL/RETURN into a registered jump request, and
// squashes the wrong-path instructions that follow a taken jump.
module processor_stage3 #(
   parameter int ADDR_SIZE   = 18,
   parameter int WORD_SIZE   = 18,
   parameter int FLUSH_DEPTH = 2
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 no_operation_in,
   input  logic [WORD_SIZE-1:0] code_word_in,
   input  logic [WORD_SIZE-1:0] alu_data0_in,
   input  logic [WORD_SIZE-1:0] alu_data1_in,
   input  logic [ADDR_SIZE-1:0] ip_in,
   input  logic [ADDR_SIZE-1:0] ip_plus_one_in,
   input  logic [ADDR_SIZE-1:0] data1_plus_imm8_in,
   input  logic [WORD_SIZE-1:0] memory_read_data,
   output logic                 writeback_reg_write_enable,
   output logic [2:0]           writeback_reg_write_addr,
   output logic [WORD_SIZE-1:0] writeback_reg_write_data,
   output logic                 jump_enable,
   output logic [ADDR_SIZE-1:0] jump_addr
);

   typedef enum logic [3:0] {
      OP_REG_ADD_IMM8      = 4'd0,
      OP_REG_MOV_IMM11     = 4'd1,
      OP_REG_MOV_IMM11_TOP = 4'd2,
      OP_LOAD_FROM_MEMORY  = 4'd3,
      OP_WRITE_TO_MEMORY   = 4'd4,
      OP_ALU               = 4'd5,
      OP_MUL_SHIFT         = 4'd6,
      OP_IF                = 4'd7,
      OP_CALL_IMM14        = 4'd8,
      OP_RETURN            = 4'd9,
      OP_WAIT              = 4'd10
   } opcode_t;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_XOR = 4'd4,
      ALU_SHL = 4'd5,
      ALU_SHR = 4'd6,
      ALU_SAR = 4'd7
   } alu_op_t;

   typedef enum logic [2:0] {
      COND_EQ_ZERO = 3'd0,
      COND_NE_ZERO = 3'd1,
      COND_LT_ZERO = 3'd2,
      COND_GE_ZERO = 3'd3,
      COND_GT_ZERO = 3'd4,
      COND_LE_ZERO = 3'd5,
      COND_ALWAYS  = 3'd6,
      COND_NEVER   = 3'd7
   } cond_t;

   opcode_t                        opcode;
   alu_op_t                        alu_op;
   cond_t                          cond;
   logic [2:0]                     dest_reg;
   logic [1:0]                     squash_count;
   logic                           active;

   logic [WORD_SIZE-1:0]           alu_result;
   logic [WORD_SIZE-1:0]           mul_result;
   logic signed [2*WORD_SIZE-1:0]  product;
   logic signed [2*WORD_SIZE-1:0]  product_shifted;
   logic [4:0]                     alu_shift;
   logic                           data0_zero;
   logic                           data0_negative;
   logic                           cond_true;
   logic [WORD_SIZE-1:0]           imm11_word;

   logic                           next_write_enable;
   logic [2:0]                     next_write_addr;
   logic [WORD_SIZE-1:0]           next_write_data;
   logic                           next_jump_enable;
   logic [ADDR_SIZE-1:0]           next_jump_addr;

   // ip+1 is consumed by stage 2 for the CALL return address, not here
   logic                           unused_ip_plus_one;
   assign unused_ip_plus_one = ^ip_plus_one_in;

   assign opcode     = opcode_t'(code_word_in[17:14]);
   assign alu_op     = alu_op_t'(code_word_in[3:0]);
   assign cond       = cond_t'(code_word_in[7:5]);
   assign dest_reg   = code_word_in[13:11];
   assign alu_shift  = alu_data1_in[4:0];
   assign imm11_word = {{(WORD_SIZE-11){1'b0}}, code_word_in[10:0]};

   // An instruction executes only when it is not a bubble and no flush is pending
   assign active = !no_operation_in && (squash_count == 2'd0);

   // ALU datapath
   always_comb begin
      alu_result = '0;
      case (alu_op)
         ALU_ADD: alu_result = alu_data0_in + alu_data1_in;
         ALU_SUB: alu_result = alu_data0_in - alu_data1_in;
         ALU_AND: alu_result = alu_data0_in & alu_data1_in;
         ALU_OR:  alu_result = alu_data0_in | alu_data1_in;
         ALU_XOR: alu_result = alu_data0_in ^ alu_data1_in;
         ALU_SHL: alu_result = alu_data0_in << alu_shift;
         ALU_SHR: alu_result = alu_data0_in >> alu_shift;
         ALU_SAR: alu_result = $signed(alu_data0_in) >>> alu_shift;
         default: alu_result = '0;
      endcase
   end

   // Signed full-width multiply followed by arithmetic right shift
   always_comb begin
      product         = $signed(alu_data0_in) * $signed(alu_data1_in);
      product_shifted = product >>> code_word_in[4:0];
      mul_result      = product_shifted[WORD_SIZE-1:0];
   end

   // Branch condition evaluated on signed rx
   always_comb begin
      data0_zero     = (alu_data0_in == '0);
      data0_negative = alu_data0_in[WORD_SIZE-1];
      cond_true      = 1'b0;
      case (cond)
         COND_EQ_ZERO: cond_true = data0_zero;
         COND_NE_ZERO: cond_true = !data0_zero;
         COND_LT_ZERO: cond_true = data0_negative;
         COND_GE_ZERO: cond_true = !data0_negative;
         COND_GT_ZERO: cond_true = !data0_negative && !data0_zero;
         COND_LE_ZERO: cond_true = data0_negative || data0_zero;
         COND_ALWAYS:  cond_true = 1'b1;
         COND_NEVER:   cond_true = 1'b0;
         default:      cond_true = 1'b0;
      endcase
   end

   // Decode opcode into next writeback and jump request
   always_comb begin
      next_write_enable = 1'b0;
      next_write_addr   = 3'd0;
      next_write_data   = '0;
      next_jump_enable  = 1'b0;
      next_jump_addr    = '0;
      if (active) begin
         case (opcode)
            OP_REG_ADD_IMM8: begin
               next_write_enable = 1'b1;
               next_write_addr   = dest_reg;
               next_write_data   = WORD_SIZE'(data1_plus_imm8_in);
            end
            OP_REG_MOV_IMM11: begin
               next_write_enable = 1'b1;
               next_write_addr   = dest_reg;
               next_write_data   = imm11_word;
            end
            OP_REG_MOV_IMM11_TOP: begin
               next_write_enable = 1'b1;
               next_write_addr   = dest_reg;
               next_write_data   = imm11_word << 7;
            end
            OP_LOAD_FROM_MEMORY: begin
               next_write_enable = 1'b1;
               next_write_addr   = dest_reg;
               next_write_data   = memory_read_data;
            end
            OP_ALU: begin
               next_write_enable = 1'b1;
               next_write_addr   = dest_reg;
               next_write_data   = alu_result;
            end
            OP_MUL_SHIFT: begin
               next_write_enable = 1'b1;
               next_write_addr   = dest_reg;
               next_write_data   = mul_result;
            end
            OP_IF: begin
               next_jump_enable = cond_true;
               if (cond_true)
                  next_jump_addr = ip_in + {{(ADDR_SIZE-5){code_word_in[4]}}, code_word_in[4:0]};
            end
            OP_CALL_IMM14: begin
               next_jump_enable = 1'b1;
               next_jump_addr   = {{(ADDR_SIZE-14){1'b0}}, code_word_in[13:0]};
            end
            OP_RETURN: begin
               next_jump_enable = 1'b1;
               next_jump_addr   = memory_read_data[ADDR_SIZE-1:0];
            end
            default: begin
               next_write_enable = 1'b0;
               next_jump_enable  = 1'b0;
            end
         endcase
      end
   end

   // Output registers and squash counter; a taken jump can only start when
   // the counter is already zero, so loading and decrementing never collide
   always_ff @(posedge clock) begin
      if (reset) begin
         writeback_reg_write_enable <= 1'b0;
         writeback_reg_write_addr   <= 3'd0;
         writeback_reg_write_data   <= '0;
         jump_enable                <= 1'b0;
         jump_addr                  <= '0;
         squash_count               <= 2'd0;
      end else begin
         writeback_reg_write_enable <= next_write_enable;
         writeback_reg_write_addr   <= next_write_addr;
         writeback_reg_write_data   <= next_write_data;
         jump_enable                <= next_jump_enable;
         jump_addr                  <= next_jump_addr;
         if (next_jump_enable)
            squash_count <= 2'(FLUSH_DEPTH);
         else if (squash_count != 2'd0)
            squash_count <= squash_count - 2'd1;
      end
   end

endmodule

// File: tb/tb_processor_stage3.sv
// Self-checking bench for processor_stage3: directed scenarios plus a
// randomized run against an arithmetic reference model.
module tb_processor_stage3;

   localparam int FLUSH = 2;
   localparam longint MOD = 262144;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        no_operation_in = 1'b0;
   logic [17:0] code_word_in = '0;
   logic [17:0] alu_data0_in = '0;
   logic [17:0] alu_data1_in = '0;
   logic [17:0] ip_in = '0;
   logic [17:0] ip_plus_one_in = '0;
   logic [17:0] data1_plus_imm8_in = '0;
   logic [17:0] memory_read_data = '0;
   logic        writeback_reg_write_enable;
   logic [2:0]  writeback_reg_write_addr;
   logic [17:0] writeback_reg_write_data;
   logic        jump_enable;
   logic [17:0] jump_addr;

   int total = 0;
   int bad = 0;

   // reference model state and expectations
   int          m_squash = 0;
   logic        e_we;
   logic [2:0]  e_addr;
   logic [17:0] e_data;
   logic        e_jump;
   logic [17:0] e_jaddr;

   processor_stage3 #(.ADDR_SIZE(18), .WORD_SIZE(18), .FLUSH_DEPTH(FLUSH)) dut (
      .clock(clock),
      .reset(reset),
      .no_operation_in(no_operation_in),
      .code_word_in(code_word_in),
      .alu_data0_in(alu_data0_in),
      .alu_data1_in(alu_data1_in),
      .ip_in(ip_in),
      .ip_plus_one_in(ip_plus_one_in),
      .data1_plus_imm8_in(data1_plus_imm8_in),
      .memory_read_data(memory_read_data),
      .writeback_reg_write_enable(writeback_reg_write_enable),
      .writeback_reg_write_addr(writeback_reg_write_addr),
      .writeback_reg_write_data(writeback_reg_write_data),
      .jump_enable(jump_enable),
      .jump_addr(jump_addr)
   );

   always #5 clock = ~clock;

   function automatic logic [17:0] enc(input logic [3:0] op, input logic [2:0] rx, input logic [10:0] low);
      return {op, rx, low};
   endfunction

   function automatic longint to_signed(input logic [17:0] v);
      longint x = longint'(v);
      if (x >= MOD / 2) x = x - MOD;
      return x;
   endfunction

   function automatic logic [17:0] wrap(input longint x);
      longint r = x % MOD;
      if (r < 0) r = r + MOD;
      return 18'(r);
   endfunction

   function automatic longint floor_div_pow2(input longint x, input int unsigned sh);
      longint d = longint'(1) << sh;
      longint q = x / d;
      if (x < 0 && (x % d) != 0) q = q - 1;
      return q;
   endfunction

   // Reference: what the outputs must be one cycle after these inputs
   function automatic void model_step(input logic nop, input logic [17:0] cw, a0, a1, ip, d1, mem);
      longint sa0 = to_signed(a0);
      longint sa1 = to_signed(a1);
      longint ua0 = longint'(a0);
      longint ua1 = longint'(a1);
      int unsigned amt = int'(a1[4:0]);
      longint off;
      logic take;
      e_we = 0; e_addr = 0; e_data = 0; e_jump = 0; e_jaddr = 0;
      if (nop || m_squash > 0) begin
         if (m_squash > 0) m_squash = m_squash - 1;
         return;
      end
      e_addr = cw[13:11];
      case (int'(cw[17:14]))
         0: begin e_we = 1; e_data = d1; end
         1: begin e_we = 1; e_data = wrap(longint'(cw[10:0])); end
         2: begin e_we = 1; e_data = wrap(longint'(cw[10:0]) * 128); end
         3: begin e_we = 1; e_data = mem; end
         5: begin
            e_we = 1;
            case (int'(cw[3:0]))
               0: e_data = wrap(ua0 + ua1);
               1: e_data = wrap(ua0 - ua1);
               2: e_data = a0 & a1;
               3: e_data = a0 | a1;
               4: e_data = a0 ^ a1;
               5: e_data = wrap(ua0 * (longint'(1) << amt));
               6: e_data = wrap(ua0 / (longint'(1) << amt));
               7: e_data = wrap(floor_div_pow2(sa0, amt));
               default: e_data = 0;
            endcase
         end
         6: begin e_we = 1; e_data = wrap(floor_div_pow2(sa0 * sa1, int'(cw[4:0]))); end
         7: begin
            case (int'(cw[7:5]))
               0: take = (sa0 == 0);
               1: take = (sa0 != 0);
               2: take = (sa0 < 0);
               3: take = (sa0 >= 0);
               4: take = (sa0 > 0);
               5: take = (sa0 <= 0);
               6: take = 1;
               default: take = 0;
            endcase
            off = longint'(cw[4:0]);
            if (off >= 16) off = off - 32;
            e_jump = take;
            if (take) e_jaddr = wrap(longint'(ip) + off);
         end
         8: begin e_jump = 1; e_jaddr = {4'd0, cw[13:0]}; end
         9: begin e_jump = 1; e_jaddr = mem; end
         default: ;
      endcase
      if (e_jump) m_squash = FLUSH;
   endfunction

   task automatic drive(input logic nop, input logic [17:0] cw, a0, a1, ip, d1, mem);
      no_operation_in    = nop;
      code_word_in       = cw;
      alu_data0_in       = a0;
      alu_data1_in       = a1;
      ip_in              = ip;
      ip_plus_one_in     = ip + 18'd1;
      data1_plus_imm8_in = d1;
      memory_read_data   = mem;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, enc(4'd9, 3'($urandom), 11'($urandom)), 18'($urandom), 18'($urandom),
               18'($urandom), 18'($urandom), 18'($urandom));
         total++;
         if ({writeback_reg_write_enable, writeback_reg_write_addr, writeback_reg_write_data,
              jump_enable, jump_addr} !== 40'd0) begin
            bad++;
            $display("FAIL reset_outputs cycle=%0d got we=%b addr=%0d data=%h jump=%b jaddr=%h want all 0",
                     i, writeback_reg_write_enable, writeback_reg_write_addr,
                     writeback_reg_write_data, jump_enable, jump_addr);
         end
      end
      reset = 1'b0;
      drive(1'b0, enc(4'd0, 3'd5, 11'd0), 18'd0, 18'd0, 18'd0, 18'h00155, 18'd0);
      total++;
      if ({writeback_reg_write_enable, writeback_reg_write_addr, writeback_reg_write_data} !==
          {1'b1, 3'd5, 18'h00155}) begin
         bad++;
         $display("FAIL first_after_reset got we=%b addr=%0d data=%h want we=1 addr=5 data=00155",
                  writeback_reg_write_enable, writeback_reg_write_addr, writeback_reg_write_data);
      end
   endtask

   task automatic test_alu_sub();
      drive(1'b0, enc(4'd5, 3'd3, 11'd1), 18'd5, 18'd7, 18'd10, 18'd0, 18'd0);
      total++;
      if ({writeback_reg_write_enable, writeback_reg_write_addr, writeback_reg_write_data} !==
          {1'b1, 3'd3, 18'h3FFFE}) begin
         bad++;
         $display("FAIL alu_sub got we=%b addr=%0d data=%h want we=1 addr=3 data=3fffe",
                  writeback_reg_write_enable, writeback_reg_write_addr, writeback_reg_write_data);
      end
      drive(1'b1, '0, '0, '0, '0, '0, '0);
      total++;
      if (writeback_reg_write_enable !== 1'b0) begin
         bad++;
         $display("FAIL alu_sub_pulse got we=%b want 0", writeback_reg_write_enable);
      end
   endtask

   task automatic test_mul_shift();
      drive(1'b0, enc(4'd6, 3'd6, 11'd2), 18'h3FFFD, 18'd1000, 18'd0, 18'd0, 18'd0);
      total++;
      if ({writeback_reg_write_enable, writeback_reg_write_addr, writeback_reg_write_data} !==
          {1'b1, 3'd6, 18'h3FD12}) begin
         bad++;
         $display("FAIL mul_shift got we=%b addr=%0d data=%h want we=1 addr=6 data=3fd12",
                  writeback_reg_write_enable, writeback_reg_write_addr, writeback_reg_write_data);
      end
   endtask

   task automatic test_if_taken();
      drive(1'b0, enc(4'd7, 3'd1, {3'd0, 3'd0, 5'b11100}), 18'd0, 18'd100, 18'd100, 18'd96, 18'd0);
      total++;
      if ({jump_enable, jump_addr, writeback_reg_write_enable} !== {1'b1, 18'd96, 1'b0}) begin
         bad++;
         $display("FAIL if_taken got jump=%b jaddr=%0d we=%b want jump=1 jaddr=96 we=0",
                  jump_enable, jump_addr, writeback_reg_write_enable);
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, enc(4'd0, 3'd2, 11'd0), 18'd0, 18'd0, 18'd101, 18'd40 + 18'(i), 18'd0);
         total++;
         if (i < 2) begin
            if ({writeback_reg_write_enable, jump_enable} !== 2'b00) begin
               bad++;
               $display("FAIL if_squash idx=%0d got we=%b jump=%b want we=0 jump=0",
                        i, writeback_reg_write_enable, jump_enable);
            end
         end else begin
            if ({writeback_reg_write_enable, writeback_reg_write_data} !== {1'b1, 18'd42}) begin
               bad++;
               $display("FAIL if_after_squash got we=%b data=%0d want we=1 data=42",
                        writeback_reg_write_enable, writeback_reg_write_data);
            end
         end
      end
   endtask

   task automatic test_if_not_taken();
      drive(1'b0, enc(4'd7, 3'd1, {3'd0, 3'd0, 5'b11100}), 18'd1, 18'd100, 18'd100, 18'd96, 18'd0);
      total++;
      if (jump_enable !== 1'b0) begin
         bad++;
         $display("FAIL if_not_taken got jump=%b want 0", jump_enable);
      end
      drive(1'b0, enc(4'd0, 3'd4, 11'd0), 18'd0, 18'd0, 18'd101, 18'd77, 18'd0);
      total++;
      if ({writeback_reg_write_enable, writeback_reg_write_addr, writeback_reg_write_data} !==
          {1'b1, 3'd4, 18'd77}) begin
         bad++;
         $display("FAIL if_not_taken_next got we=%b addr=%0d data=%0d want we=1 addr=4 data=77",
                  writeback_reg_write_enable, writeback_reg_write_addr, writeback_reg_write_data);
      end
   endtask

   task automatic test_return_reset();
      drive(1'b0, enc(4'd9, 3'd0, 11'd0), 18'd0, 18'd0, 18'd200, 18'd0, 18'h00123);
      total++;
      if ({jump_enable, jump_addr} !== {1'b1, 18'h00123}) begin
         bad++;
         $display("FAIL return got jump=%b jaddr=%h want jump=1 jaddr=00123", jump_enable, jump_addr);
      end
      reset = 1'b1;
      drive(1'b0, enc(4'd0, 3'd7, 11'd0), 18'd0, 18'd0, 18'd0, 18'd9, 18'd0);
      reset = 1'b0;
      total++;
      if ({writeback_reg_write_enable, jump_enable} !== 2'b00) begin
         bad++;
         $display("FAIL return_reset got we=%b jump=%b want 0 0", writeback_reg_write_enable, jump_enable);
      end
      drive(1'b0, enc(4'd1, 3'd7, 11'h5A5), 18'd0, 18'd0, 18'd0, 18'd0, 18'd0);
      total++;
      if ({writeback_reg_write_enable, writeback_reg_write_addr, writeback_reg_write_data} !==
          {1'b1, 3'd7, 18'h005A5}) begin
         bad++;
         $display("FAIL return_reset_next got we=%b addr=%0d data=%h want we=1 addr=7 data=005a5",
                  writeback_reg_write_enable, writeback_reg_write_addr, writeback_reg_write_data);
      end
   endtask

   task automatic test_random();
      logic        nop;
      logic [17:0] cw, a0, a1, ip, d1, mem;
      m_squash = 0;
      for (int i = 0; i < 400; i++) begin
         nop = ($urandom_range(0, 4) == 0);
         cw  = {4'($urandom_range(0, 15)), 14'($urandom)};
         case ($urandom_range(0, 4))
            0: a0 = 18'd0;
            1: a0 = 18'd1;
            2: a0 = 18'h3FFFF;
            default: a0 = 18'($urandom);
         endcase
         a1  = 18'($urandom);
         ip  = 18'($urandom);
         d1  = 18'($urandom);
         mem = 18'($urandom);
         model_step(nop, cw, a0, a1, ip, d1, mem);
         drive(nop, cw, a0, a1, ip, d1, mem);
         total++;
         if ({writeback_reg_write_enable, jump_enable} !== {e_we, e_jump}) begin
            bad++;
            $display("FAIL rand_strobes i=%0d cw=%h got we=%b jump=%b want we=%b jump=%b",
                     i, cw, writeback_reg_write_enable, jump_enable, e_we, e_jump);
         end
         if (e_we) begin
            total++;
            if ({writeback_reg_write_addr, writeback_reg_write_data} !== {e_addr, e_data}) begin
               bad++;
               $display("FAIL rand_write i=%0d cw=%h got addr=%0d data=%h want addr=%0d data=%h",
                        i, cw, writeback_reg_write_addr, writeback_reg_write_data, e_addr, e_data);
            end
         end
         if (e_jump) begin
            total++;
            if (jump_addr !== e_jaddr) begin
               bad++;
               $display("FAIL rand_jump i=%0d cw=%h got jaddr=%h want %h", i, cw, jump_addr, e_jaddr);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_alu_sub();
      test_mul_shift();
      test_if_taken();
      test_if_not_taken();
      test_return_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
